// File: rtl/pq_pkg.sv
// Shared types for the priority-queue access arbiter: key type, queue command
// encoding and arbiter FSM states.
package pq_pkg;

  localparam int PQ_DATA_WIDTH = 12;

  typedef logic [PQ_DATA_WIDTH-1:0] key_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_PUSH,
    CMD_POP,
    CMD_REPLACE
  } pq_cmd_e;

  typedef enum logic {
    IDLE,
    COOLDOWN
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer just past the winner whenever a grant is consumed.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [N-1:0]         req_i,
  input  logic                 en_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grant_idx_o
);
  import pq_pkg::*;

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;
  logic          found;
  int            pos;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    pos         = 0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr_q) + k) % N;
      idx = IW'(pos);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && |req_i) begin
      ptr_d = (grant_idx_o == IW'(N-1)) ? '0 : grant_idx_o + IW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pq_access_arbiter.sv
// Shares one max-first priority queue between NUM_REQ requesters with
// round-robin push/pop arbitration, command spacing and push+pop merging.
//
//   state    | meaning
//   IDLE     | may issue one queue command this cycle
//   COOLDOWN | queue pipeline settling; no command, no ready
module pq_access_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 12,
  parameter int QUEUE_SIZE = 28,
  parameter int OP_GAP     = 2
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic [NUM_REQ-1:0]            i_push_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_push_data,
  output logic [NUM_REQ-1:0]            o_push_ready,
  input  logic [NUM_REQ-1:0]            i_pop_valid,
  output logic [NUM_REQ-1:0]            o_pop_ready,
  output logic                          o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    o_rsp_id,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
  output logic                          pq_wrt,
  output logic                          pq_read,
  output logic [DATA_WIDTH-1:0]         pq_data,
  input  logic                          pq_full,
  input  logic                          pq_empty,
  input  logic [DATA_WIDTH-1:0]         pq_rdata
);
  import pq_pkg::*;

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(QUEUE_SIZE+1);
  localparam int GAP_W = $clog2(OP_GAP+1);

  arb_state_e          state_q;
  logic [GAP_W-1:0]    gap_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic [NUM_REQ-1:0]  push_grant, pop_grant, pop_req;
  logic [ID_W-1:0]     push_idx, pop_idx;
  logic                push_ok, pop_ok, push_en, pop_en;
  logic [DATA_WIDTH-1:0] push_key;
  pq_cmd_e             cmd;

  assign push_ok = (count_q < CNT_W'(QUEUE_SIZE)) && !pq_full;
  assign pop_ok  = (count_q != '0) && !pq_empty;
  assign pop_req = i_pop_valid & {NUM_REQ{pop_ok}};

  // Push side sees raw requests so a full queue can still take a replace.
  always_comb begin
    cmd = CMD_NONE;
    if (state_q == IDLE) begin
      if (|i_push_valid && |pop_req)      cmd = CMD_REPLACE;
      else if (|i_push_valid && push_ok)  cmd = CMD_PUSH;
      else if (|pop_req)                  cmd = CMD_POP;
    end
  end

  assign push_en = (cmd == CMD_PUSH) || (cmd == CMD_REPLACE);
  assign pop_en  = (cmd == CMD_POP)  || (cmd == CMD_REPLACE);

  rr_arbiter #(.N(NUM_REQ)) u_push_arb (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .req_i      (i_push_valid),
    .en_i       (push_en),
    .grant_o    (push_grant),
    .grant_idx_o(push_idx)
  );

  rr_arbiter #(.N(NUM_REQ)) u_pop_arb (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .req_i      (pop_req),
    .en_i       (pop_en),
    .grant_o    (pop_grant),
    .grant_idx_o(pop_idx)
  );

  always_comb begin
    push_key = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (push_grant[k]) push_key = i_push_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    count_d = count_q;
    case (cmd)
      CMD_PUSH: count_d = count_q + CNT_W'(1);
      CMD_POP:  count_d = count_q - CNT_W'(1);
      default:  count_d = count_q;
    endcase
  end

  assign o_push_ready = push_grant & {NUM_REQ{push_en}};
  assign o_pop_ready  = pop_grant & {NUM_REQ{pop_en}};
  assign pq_wrt       = push_en;
  assign pq_read      = pop_en;
  assign pq_data      = push_en ? push_key : '0;
  assign o_count      = count_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_id     = rsp_id_q;
  assign o_rsp_data   = rsp_data_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      count_q     <= count_d;
      rsp_valid_q <= pop_en;
      // Top-of-heap before the command is what the popper receives.
      if (pop_en) begin
        rsp_id_q   <= pop_idx;
        rsp_data_q <= pq_rdata;
      end
      case (state_q)
        IDLE: begin
          if (cmd != CMD_NONE) begin
            gap_q <= GAP_W'(OP_GAP-1);
            if (OP_GAP > 1) state_q <= COOLDOWN;
          end
        end
        COOLDOWN: begin
          gap_q <= gap_q - GAP_W'(1);
          if (gap_q <= GAP_W'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
